// File: rtl/jpeg_bitstream_packer.sv
// Packs variable-length Huffman code words MSB-first into a byte stream with
// 0xFF/0x00 stuffing and 1-padding on flush; valid/ready on both sides.
module jpeg_bitstream_packer #(
   parameter int unsigned CODE_W   = 32,
   parameter int unsigned LEN_W    = 6,
   parameter int unsigned ACC_W    = 64,
   parameter bit          STUFF_EN = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic [LEN_W-1:0]  in_len,
   input  logic              in_flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_byte,
   output logic              out_stuffed,
   output logic              busy,
   output logic              flush_done
);

   localparam int unsigned CNT_W = $clog2(ACC_W + 1);

   typedef enum logic [1:0] {StRun, StPad, StDrain, StDone} state_e;

   state_e           r_state, w_state_nxt;
   logic [ACC_W-1:0] r_acc, w_acc_nxt;
   logic [CNT_W-1:0] r_count, w_count_nxt;
   logic             r_stuff_pend;
   logic             r_out_valid;
   logic [7:0]       r_out_byte;
   logic             r_out_stuffed;

   logic             w_take;
   logic             w_flush_take;
   logic             w_out_free;
   logic             w_load_stuff;
   logic             w_ext;
   logic [LEN_W-1:0] w_len;
   logic [7:0]       w_top;
   logic [2:0]       w_pad;

   assign in_ready     = (r_state == StRun) && (r_count <= CNT_W'(ACC_W - CODE_W));
   assign w_take       = in_valid && in_ready;
   assign w_flush_take = in_flush && in_ready;
   assign w_len        = (in_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : in_len;

   // A pending stuff byte has priority over the next accumulator byte.
   assign w_out_free   = !r_out_valid || out_ready;
   assign w_load_stuff = w_out_free && r_stuff_pend;
   assign w_ext        = w_out_free && !r_stuff_pend && (r_count >= CNT_W'(8));
   assign w_top        = 8'(r_acc >> (r_count - CNT_W'(8)));
   assign w_pad        = 3'd0 - r_count[2:0];

   // Extraction reads the pre-append accumulator; bits above count are don't-care.
   always_comb begin
      w_acc_nxt   = r_acc;
      w_count_nxt = r_count - (w_ext ? CNT_W'(8) : CNT_W'(0));
      if (w_take) begin
         w_acc_nxt   = (r_acc << w_len)
                     | (ACC_W'(in_code) & ((ACC_W'(1) << w_len) - ACC_W'(1)));
         w_count_nxt = w_count_nxt + CNT_W'(w_len);
      end else if (r_state == StPad) begin
         w_acc_nxt   = (r_acc << w_pad) | ((ACC_W'(1) << w_pad) - ACC_W'(1));
         w_count_nxt = w_count_nxt + CNT_W'(w_pad);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      flush_done  = 1'b0;
      unique case (r_state)
         StRun:   if (w_flush_take) w_state_nxt = StPad;
         StPad:   w_state_nxt = StDrain;
         StDrain: if (r_count == '0 && !r_stuff_pend && w_out_free) w_state_nxt = StDone;
         StDone: begin
            flush_done  = 1'b1;
            w_state_nxt = StRun;
         end
         default: w_state_nxt = StRun;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= StRun;
         r_acc         <= '0;
         r_count       <= '0;
         r_stuff_pend  <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_byte    <= 8'h00;
         r_out_stuffed <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_count <= w_count_nxt;
         if (w_load_stuff) begin
            r_out_valid   <= 1'b1;
            r_out_byte    <= 8'h00;
            r_out_stuffed <= 1'b1;
            r_stuff_pend  <= 1'b0;
         end else if (w_ext) begin
            r_out_valid   <= 1'b1;
            r_out_byte    <= w_top;
            r_out_stuffed <= 1'b0;
            r_stuff_pend  <= STUFF_EN && (w_top == 8'hFF);
         end else if (w_out_free) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_byte    = r_out_byte;
   assign out_stuffed = r_out_stuffed;
   assign busy        = (r_count != '0) || r_stuff_pend || r_out_valid || (r_state != StRun);

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Bench for jpeg_bitstream_packer: cycle-exact vector table, random traffic against a
// bit-queue reference model, backpressure and mid-stream reset sequences.
module tb_jpeg_bitstream_packer;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_code;
   logic [5:0]  in_len;
   logic        in_flush;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_byte;
   logic        out_stuffed;
   logic        busy;
   logic        flush_done;

   logic        ns_in_ready;
   logic        ns_out_valid;
   logic [7:0]  ns_out_byte;
   logic        ns_out_stuffed;
   logic        ns_busy;
   logic        ns_flush_done;

   logic        rnd_ordy;
   logic        rnd_val;
   logic        tbl_ordy;
   logic        mon_en;

   int          errors;
   int          checks;
   int          rx;

   assign out_ready = rnd_ordy ? rnd_val : tbl_ordy;

   jpeg_bitstream_packer dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_code     (in_code),
      .in_len      (in_len),
      .in_flush    (in_flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_byte    (out_byte),
      .out_stuffed (out_stuffed),
      .busy        (busy),
      .flush_done  (flush_done)
   );

   jpeg_bitstream_packer #(.STUFF_EN(1'b0)) dut_ns (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (ns_in_ready),
      .in_code     (in_code),
      .in_len      (in_len),
      .in_flush    (in_flush),
      .out_valid   (ns_out_valid),
      .out_ready   (out_ready),
      .out_byte    (ns_out_byte),
      .out_stuffed (ns_out_stuffed),
      .busy        (ns_busy),
      .flush_done  (ns_flush_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference model: a plain bit queue chopped into bytes, 0x00 after every 0xFF.
   typedef struct {
      logic [7:0] b;
      logic       st;
   } ob_t;

   bit  bq[$];
   ob_t exp_q[$];

   typedef struct {
      logic        v;
      logic [31:0] code;
      logic [5:0]  len;
      logic        f;
      logic        e_ov;
      logic [7:0]  e_byte;
      logic        e_st;
      logic        e_ir;
      logic        e_fd;
      logic        e_busy;
      logic        e_nsov;
      logic [7:0]  e_nsbyte;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_emit();
      ob_t o;
      logic [7:0] b;
      while (bq.size() >= 8) begin
         b = 8'h00;
         for (int i = 0; i < 8; i++) b = {b[6:0], bq.pop_front()};
         o.b = b;
         o.st = 1'b0;
         exp_q.push_back(o);
         if (b == 8'hFF) begin
            o.b = 8'h00;
            o.st = 1'b1;
            exp_q.push_back(o);
         end
      end
   endtask

   task automatic model_append(input logic [31:0] code, input int len);
      for (int i = len - 1; i >= 0; i--) bq.push_back(code[i]);
      model_emit();
   endtask

   task automatic model_pad();
      while (bq.size() % 8 != 0) bq.push_back(1'b1);
      model_emit();
   endtask

   task automatic sync();
      @(posedge clock);
      #1;
   endtask

   // Must be called just after a rising edge.
   task automatic drive(input logic [31:0] code, input logic [5:0] len, input logic v,
                        input logic f);
      bit ok;
      int w;
      in_valid = v;
      in_code  = code;
      in_len   = len;
      in_flush = f;
      ok = 1'b0;
      w  = 0;
      while (!ok && w < 300) begin
         @(negedge clock);
         if (in_ready) ok = 1'b1;
         w++;
      end
      if (!ok) begin
         chk("drive in_ready", 32'(in_ready), 32'd1);
      end else begin
         @(posedge clock);
         if (v) model_append(code, (len > 6'd32) ? 32 : int'(len));
         if (f) model_pad();
      end
      #1;
      in_valid = 1'b0;
      in_flush = 1'b0;
   endtask

   task automatic wait_flush(input string nm);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(negedge clock);
         if (flush_done) got = 1'b1;
      end
      chk({nm, " flush_done seen"}, 32'(got), 32'd1);
      chk({nm, " drained"}, 32'(exp_q.size()), 32'd0);
      @(negedge clock);
      chk({nm, " flush_done pulse"}, 32'(flush_done), 32'd0);
      chk({nm, " busy idle"}, 32'(busy), 32'd0);
      sync();
   endtask

   task automatic add(input logic v, input logic [31:0] code, input logic [5:0] len,
                      input logic f, input logic ov, input logic [7:0] b, input logic st,
                      input logic ir, input logic fd, input logic bz, input logic nsov,
                      input logic [7:0] nsb);
      vec_t x;
      x.v = v; x.code = code; x.len = len; x.f = f;
      x.e_ov = ov; x.e_byte = b; x.e_st = st; x.e_ir = ir; x.e_fd = fd; x.e_busy = bz;
      x.e_nsov = nsov; x.e_nsbyte = nsb;
      vecs.push_back(x);
   endtask

   initial begin
      bit          hold_pend;
      logic [7:0]  hold_byte;
      logic        hold_st;
      ob_t         o;
      int          r;
      logic [5:0]  l;
      logic [31:0] c;

      errors = 0; checks = 0; rx = 0;
      reset_n = 1'b0; in_valid = 1'b0; in_code = '0; in_len = '0; in_flush = 1'b0;
      rnd_ordy = 1'b0; rnd_val = 1'b0; tbl_ordy = 1'b1; mon_en = 1'b0;
      hold_pend = 1'b0; hold_byte = 8'h00; hold_st = 1'b0;

      fork
         forever begin
            @(posedge clock);
            #1;
            rnd_val = ($urandom_range(0, 3) != 0);
         end
         forever begin
            @(negedge clock);
            if (mon_en && reset_n) begin
               if (hold_pend) begin
                  chk("hold out_valid", 32'(out_valid), 32'd1);
                  chk("hold out_byte", 32'(out_byte), 32'(hold_byte));
                  chk("hold out_stuffed", 32'(out_stuffed), 32'(hold_st));
               end
               hold_pend = out_valid && !out_ready;
               hold_byte = out_byte;
               hold_st   = out_stuffed;
               if (out_valid && out_ready) begin
                  rx++;
                  if (exp_q.size() == 0) begin
                     chk("unexpected byte", 32'(out_byte), 32'hFFFF_FFFF);
                  end else begin
                     o = exp_q.pop_front();
                     chk("stream byte", 32'(out_byte), 32'(o.b));
                     chk("stream stuffed", 32'(out_stuffed), 32'(o.st));
                  end
               end
            end else begin
               hold_pend = 1'b0;
            end
         end
      join_none

      // Single code with garbage above in_len, then a separate flush.
      add(1, 32'hFFFF_FFFD, 6'd3, 0,  0, 8'h00, 0, 1, 0, 0,  0, 8'h00);
      add(0, 32'h0, 6'd0, 1,          0, 8'h00, 0, 1, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 0, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 0, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          1, 8'hBF, 0, 0, 0, 1,  1, 8'hBF);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 0, 1, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 1, 0, 0,  0, 8'h00);
      // 0xFF then 0x12: stuffed stream vs. unstuffed instance.
      add(1, 32'hFF, 6'd8, 0,         0, 8'h00, 0, 1, 0, 0,  0, 8'h00);
      add(1, 32'h12, 6'd8, 0,         0, 8'h00, 0, 1, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          1, 8'hFF, 0, 1, 0, 1,  1, 8'hFF);
      add(0, 32'h0, 6'd0, 0,          1, 8'h00, 1, 1, 0, 1,  1, 8'h12);
      add(0, 32'h0, 6'd0, 0,          1, 8'h12, 0, 1, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 1, 0, 0,  0, 8'h00);
      // Padding completes an 0xFF, which is then stuffed.
      add(1, 32'hF, 6'd4, 0,          0, 8'h00, 0, 1, 0, 0,  0, 8'h00);
      add(0, 32'h0, 6'd0, 1,          0, 8'h00, 0, 1, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 0, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 0, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          1, 8'hFF, 0, 0, 0, 1,  1, 8'hFF);
      add(0, 32'h0, 6'd0, 0,          1, 8'h00, 1, 0, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 0, 1, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 1, 0, 0,  0, 8'h00);
      // Append and flush in the same cycle.
      add(1, 32'h1, 6'd2, 1,          0, 8'h00, 0, 1, 0, 0,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 0, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 0, 0, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          1, 8'h7F, 0, 0, 0, 1,  1, 8'h7F);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 0, 1, 1,  0, 8'h00);
      add(0, 32'h0, 6'd0, 0,          0, 8'h00, 0, 1, 0, 0,  0, 8'h00);

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_byte", 32'(out_byte), 32'd0);
      chk("reset out_stuffed", 32'(out_stuffed), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset flush_done", 32'(flush_done), 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         sync();
         in_valid = vecs[i].v;
         in_code  = vecs[i].code;
         in_len   = vecs[i].len;
         in_flush = vecs[i].f;
         @(negedge clock);
         chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         if (vecs[i].e_ov) begin
            chk($sformatf("row%0d out_byte", i), 32'(out_byte), 32'(vecs[i].e_byte));
            chk($sformatf("row%0d out_stuffed", i), 32'(out_stuffed), 32'(vecs[i].e_st));
         end
         chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
         chk($sformatf("row%0d flush_done", i), 32'(flush_done), 32'(vecs[i].e_fd));
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         chk($sformatf("row%0d ns out_valid", i), 32'(ns_out_valid), 32'(vecs[i].e_nsov));
         if (vecs[i].e_nsov)
            chk($sformatf("row%0d ns out_byte", i), 32'(ns_out_byte), 32'(vecs[i].e_nsbyte));
      end
      in_valid = 1'b0;
      in_flush = 1'b0;

      // Random traffic with random backpressure and occasional flushes.
      sync();
      mon_en = 1'b1;
      rnd_ordy = 1'b1;
      for (int t = 0; t < 250; t++) begin
         r = int'($urandom_range(0, 15));
         l = 6'($urandom_range(0, 40));
         c = $urandom;
         if (r == 0) drive(c, l, 1'b0, 1'b1);
         else if (r == 1) drive(c, l, 1'b1, 1'b1);
         else drive(c, l, 1'b1, 1'b0);
         if (r <= 1) wait_flush("rand");
      end
      drive(32'h0, 6'd0, 1'b0, 1'b1);
      wait_flush("final");

      // Long stall: accumulator fills until in_ready drops, then drains in order.
      rnd_ordy = 1'b0;
      tbl_ordy = 1'b0;
      fork
         begin
            for (int k = 1; k <= 8; k++) drive(32'(k), 6'd8, 1'b1, 1'b0);
         end
         begin
            repeat (20) @(negedge clock);
            chk("bp stall out_valid", 32'(out_valid), 32'd1);
            chk("bp stall out_byte", 32'(out_byte), 32'h01);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
            sync();
            tbl_ordy = 1'b1;
         end
      join
      for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clock);
      chk("bp drained", 32'(exp_q.size()), 32'd0);
      sync();

      // Reset while a byte is held and 13 bits remain buffered.
      mon_en = 1'b0;
      tbl_ordy = 1'b0;
      drive(32'h11, 6'd8, 1'b1, 1'b0);
      drive(32'h1ABC, 6'd13, 1'b1, 1'b0);
      @(negedge clock);
      chk("pre-reset out_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid-reset out_valid", 32'(out_valid), 32'd0);
      chk("mid-reset busy", 32'(busy), 32'd0);
      bq.delete();
      exp_q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      tbl_ordy = 1'b1;
      rx = 0;
      mon_en = 1'b1;
      sync();
      drive(32'hA5, 6'd8, 1'b1, 1'b0);
      repeat (10) @(negedge clock);
      chk("post-reset byte count", 32'(rx), 32'd1);
      chk("post-reset drained", 32'(exp_q.size()), 32'd0);
      chk("post-reset busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jpeg_bitstream_packer.md
# jpeg_bitstream_packer

Parametrised output stage for the JPEG encoder: takes variable-length Huffman code words (code plus appended magnitude bits) from the Huffman encode controller and packs them MSB-first into a byte stream. It inserts the mandatory 0x00 after every 0xFF data byte. On flush it pads to a byte boundary with 1s. It sits between the Huffman encode controller and the top-level byte output, and replaces the fixed 8-bit `jpeg_out` / `jpeg_data_bits` pair with a valid/ready byte interface.

## Interface
- CODE_W, 32: maximum bits per input code word.
- LEN_W, 6: width of in_len; must satisfy 2^LEN_W > CODE_W.
- ACC_W, 64: bit accumulator depth; must be ≥ CODE_W+8.
- STUFF_EN, 1: 1 = insert 0x00 after each 0xFF byte; 0 = no stuffing.

Ports:
- clock, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: code word present.
- in_ready, output, 1: packer can accept a code word or flush this cycle.
- in_code, input, CODE_W: code, right-aligned; bit in_len-1 is sent first.
- in_len, input, LEN_W: valid bits in in_code, 0..CODE_W.
- in_flush, input, 1: pad and drain request; taken when in_ready is high.
- out_valid, output, 1: out_byte valid.
- out_ready, input, 1: downstream accepts out_byte.
- out_byte, output, 8: packed stream byte.
- out_stuffed, output, 1: 1 when out_byte is an inserted 0x00.
- busy, output, 1: accumulator non-empty, stuff pending, out_valid high, or a flush in progress.
- flush_done, output, 1: one-cycle pulse when a flush has fully drained.

## Operation
- State: acc[ACC_W-1:0], count (bits held, 0..ACC_W), stuff_pending, a 1-entry output register, and an FSM.
- FSM states:
  - RUN → PAD on accepted flush.
  - PAD: appends (8 − count%8)%8 one-bits in one cycle, then goes to DRAIN.
  - DRAIN → DONE when count==0, stuff_pending==0 and the output register is empty or being consumed.
  - DONE: flush_done=1 for one cycle, then returns to RUN.
- in_ready = (state==RUN) && (count ≤ ACC_W−CODE_W). Use the registered count; ignore any same-cycle extraction.
- Accept (in_valid && in_ready):
  - acc ← (acc << in_len) | (in_code & mask(in_len)); count += in_len.
  - Bits of in_code at or above in_len are ignored.
  - in_len=0 is accepted and has no effect.
  - in_len > CODE_W is illegal; the implementation clamps it to CODE_W.
- Flush with valid: in_flush && in_valid && in_ready appends the code first, then enters PAD.
- Flush without valid: in_flush && !in_valid && in_ready enters PAD directly.
- Output register loads when it is empty or out_ready=1, with this priority:
  - stuff_pending: load 0x00 with out_stuffed=1; clear stuff_pending.
  - Otherwise, if count ≥ 8: load the top byte acc[count-1 -: 8] and subtract 8 from count. If the byte is 0xFF and STUFF_EN=1, set stuff_pending.
- Extraction reads the pre-append accumulator. Append and extraction in the same cycle combine: count_next = count − 8·ext + len·acc.
- Only one byte leaves the accumulator per cycle.
- out_byte and out_stuffed hold stable while out_valid && !out_ready.
- Byte order is strictly preserved. No bits are lost or duplicated under any out_ready pattern.
- Flush with count%8==0 adds no padding.
- Flush with an empty packer goes RUN→PAD→DRAIN→DONE and emits no bytes.
- Padding that forms 0xFF is stuffed like any other byte.

## Timing
- Reset (async assert, sync release), all registers cleared: out_valid=0, out_byte=0x00, out_stuffed=0, flush_done=0, busy=0, count=0, stuff_pending=0, state=RUN.
- in_ready is 1 in the first cycle after reset release.
- Latency: code accepted at edge t makes out_valid high after edge t+1, provided count reaches ≥8 and the output register is free.
- Throughput: 1 byte/cycle with out_ready held high. A stuffed 0x00 occupies one output cycle.
- Flush latency: PAD takes 1 cycle, DRAIN takes one cycle per remaining byte (stuffed bytes included), then DONE pulses. in_ready=0 from PAD until DONE; in_ready=1 again in the cycle after DONE.
- Reset mid-operation: outputs drop at once and pending bits and stuff bytes are discarded; after release, the stream restarts with new codes only.

## Test plan
- Single code: code 0b101, len 3, then flush → out_byte 0xBF, out_stuffed=0; flush_done pulses one cycle after that byte is accepted; busy=0 afterwards.
- Stuffing: codes 0xFF/len 8 then 0x12/len 8, out_ready=1 → bytes FF, 00 (out_stuffed=1), 12 on consecutive cycles. With STUFF_EN=0 → FF, 12.
- Pad forms 0xFF: code 0xF, len 4, flush → FF then 00 (stuffed), then flush_done.
- Append and flush in the same cycle: in_valid=1, in_flush=1, code 0b01, len 2 → single byte 0x7F, then flush_done.
- Backpressure (ACC_W=64, CODE_W=32): out_ready=0 for 20 cycles while 8 codes of len 8 (0x01..0x08) are offered → in_ready drops once count>32. After release, bytes 01..08 emerge in order; out_byte is stable while stalled.
- Reset mid-stream: pull reset_n low while out_valid=1 and count=13 → out_valid=0 and busy=0 immediately. After release, code 0xA5/len 8 yields exactly one byte 0xA5.
